// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the word UART transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic        START_LVL      = 1'b0;
  localparam logic        STOP_LVL       = 1'b1;
  localparam logic        IDLE_LVL       = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Byte index 0 is the most significant byte of the word.
  function automatic logic [DATA_BITS-1:0] word_byte(input logic [31:0] word,
                                                     input logic [1:0]  idx);
    logic [DATA_BITS-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 byte serializer: owns the line FSM, baud counter and bit index.
// A byte_start in the last stop cycle chains the next byte with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_byte,
  input  logic                 i_byte_start,
  output logic                 o_tx,
  output logic                 o_byte_done,
  output logic                 o_idle
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  uart_state_e          r_state, w_state_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic [2:0]           r_bit_idx, w_bit_idx_d;
  logic [DATA_BITS-1:0] r_data, w_data_d;
  logic                 r_tx, w_tx_d;
  logic                 w_wrap;

  assign w_wrap = (r_cnt == CntMax);

  // Next-state logic; the counter reloads to zero on every state entry.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + CntW'(1);
    w_bit_idx_d = r_bit_idx;
    w_data_d    = r_data;
    o_byte_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (i_byte_start) begin
          w_state_d = StStart;
          w_data_d  = i_byte;
        end
      end
      StStart: begin
        if (w_wrap) begin
          w_state_d   = StData;
          w_cnt_d     = '0;
          w_bit_idx_d = '0;
        end
      end
      StData: begin
        if (w_wrap) begin
          w_cnt_d = '0;
          if (r_bit_idx == LastBit) begin
            w_state_d = StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (w_wrap) begin
          w_cnt_d     = '0;
          o_byte_done = 1'b1;
          if (i_byte_start) begin
            w_state_d = StStart;
            w_data_d  = i_byte;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx comes straight off a flop.
  always_comb begin
    w_tx_d = IDLE_LVL;
    unique case (w_state_d)
      StStart: w_tx_d = START_LVL;
      StData:  w_tx_d = w_data_d[w_bit_idx_d];
      StStop:  w_tx_d = STOP_LVL;
      default: w_tx_d = IDLE_LVL;
    endcase
  end

  // State, counter, shift byte and line register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_tx      <= IDLE_LVL;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_bit_idx <= w_bit_idx_d;
      r_data    <= w_data_d;
      r_tx      <= w_tx_d;
    end
  end

  assign o_tx   = r_tx;
  assign o_idle = (r_state == StIdle);

endmodule

// File: rtl/word_uart_tx.sv
// Serializes 32-bit words as four 8N1 bytes, MSB byte first, with a one-deep pending buffer.
module word_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        tx,
  output logic        busy,
  output logic        word_done,
  output logic        overflow
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  logic [31:0]          r_active, w_active_d;
  logic [31:0]          r_pending, w_pending_d;
  logic                 r_pend_full, w_pend_full_d;
  logic [1:0]           r_byte_idx, w_byte_idx_d;
  logic                 w_byte_start;
  logic                 w_byte_done;
  logic                 w_idle;
  logic                 w_word_end;
  logic [DATA_BITS-1:0] w_byte;

  assign w_word_end = w_byte_done && (r_byte_idx == LastByte);

  // Word acceptance, pending buffering and byte sequencing.
  always_comb begin
    w_active_d    = r_active;
    w_pending_d   = r_pending;
    w_pend_full_d = r_pend_full;
    w_byte_idx_d  = r_byte_idx;
    w_byte_start  = 1'b0;
    word_done     = 1'b0;
    overflow      = 1'b0;
    if (w_idle) begin
      if (word_valid) begin
        w_active_d   = word_in;
        w_byte_idx_d = '0;
        w_byte_start = 1'b1;
      end
    end else if (w_word_end) begin
      word_done    = 1'b1;
      w_byte_idx_d = '0;
      if (r_pend_full) begin
        // Pending moves up; a word arriving now takes its slot, so nothing drops.
        w_active_d    = r_pending;
        w_byte_start  = 1'b1;
        w_pend_full_d = word_valid;
        if (word_valid) begin
          w_pending_d = word_in;
        end
      end else if (word_valid) begin
        // Pending slot is empty and the line frees up this cycle: chain directly.
        w_active_d   = word_in;
        w_byte_start = 1'b1;
      end
    end else begin
      if (w_byte_done) begin
        w_byte_idx_d = r_byte_idx + 2'd1;
        w_byte_start = 1'b1;
      end
      if (word_valid) begin
        if (!r_pend_full) begin
          w_pending_d   = word_in;
          w_pend_full_d = 1'b1;
        end else begin
          overflow = 1'b1;
        end
      end
    end
    w_byte = word_byte(w_active_d, w_byte_idx_d);
  end

  // Word-level storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_byte_idx  <= '0;
    end else begin
      r_active    <= w_active_d;
      r_pending   <= w_pending_d;
      r_pend_full <= w_pend_full_d;
      r_byte_idx  <= w_byte_idx_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_byte      (w_byte),
    .i_byte_start(w_byte_start),
    .o_tx        (tx),
    .o_byte_done (w_byte_done),
    .o_idle      (w_idle)
  );

  assign busy = !w_idle || r_pend_full;

endmodule
